// File: rtl/rc_pkg.sv
// Shared types and constants for the ripple-counter timer slice.
// Latency: n/a (package only).
// Backpressure: n/a.
package rc_pkg;

    localparam int RC_W = 4;

    localparam logic [RC_W-1:0] RC_WRAP_HI = 4'hF;
    localparam logic [RC_W-1:0] RC_WRAP_LO = 4'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Step between two consecutive captured samples; a healthy counter only moves by 0 or 1.
    function automatic logic [RC_W-1:0] rc_delta(input logic [RC_W-1:0] cur, input logic [RC_W-1:0] prev);
        return cur - prev;
    endfunction

endpackage

// File: rtl/rc_timer_if.sv
// Request/status bundle between a timer client and rc_timer.
// Latency: n/a (wires only).
// Backpressure: none; start/ack are one-cycle requests, done is held until ack.
// Ports: start, target, ack (client -> timer); count, busy, done, err (timer -> client).
interface rc_timer_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] target;
    logic             ack;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             err;

    modport master (output start, output target, output ack,
                    input  count, input  busy,   input  done, input err);
    modport slave  (input  start, input  target, input  ack,
                    output count, output busy,   output done, output err);
endinterface

// File: rtl/rc_sync.sv
// Two-stage capture of the ripple counter nibble plus a primed flag.
// Latency: rc_q -> rc_s 1 clk, rc_p 2 clk; primed rises on the 2nd clk after reset release.
// Backpressure: none.
// Ports: clk, rst, rc_q in; rc_s (latest sample), rc_p (previous sample), primed out.
module rc_sync
    import rc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [RC_W-1:0] rc_q,
    output logic [RC_W-1:0] rc_s,
    output logic [RC_W-1:0] rc_p,
    output logic            primed
);

    // rc_q moves on the falling edge, so it is settled half a period before each rising edge.
    logic warm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rc_s   <= '0;
            rc_p   <= '0;
            warm   <= 1'b0;
            primed <= 1'b0;
        end else begin
            rc_s   <= rc_q;
            rc_p   <= rc_s;
            warm   <= 1'b1;
            primed <= warm;
        end
    end

endmodule

// File: rtl/rc_timer.sv
// Extends the 4-bit ripple count to a wide count and runs a one-shot interval timer on it.
// Latency: rc_q -> count 2 clk; start -> busy 1 clk; start -> done max(target+1, 2) clk.
// Backpressure: start ignored unless idle; done held until ack.
// Ports: clk, rst (async, active high), rc_q (ripple counter nibble), bus (rc_timer_if.slave).
// Build option: RC_ERR_CHECK_EN enables the sticky err flag on illegal nibble steps.
module rc_timer
    import rc_pkg::*;
#(
    parameter int UPPER_W = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RC_W-1:0] rc_q,
    rc_timer_if.slave       bus
);

    localparam int CNT_W = UPPER_W + RC_W;

    logic [RC_W-1:0]    rc_s;
    logic [RC_W-1:0]    rc_p;
    logic               primed;
    logic [UPPER_W-1:0] upper;
    logic [UPPER_W-1:0] upper_next;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   base;
    logic [CNT_W-1:0]   tgt;
    logic [CNT_W-1:0]   elapsed;
    logic               wrap;
    logic               start_ok;
    state_t             state;
    state_t             state_nxt;

    rc_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .rc_q   (rc_q),
        .rc_s   (rc_s),
        .rc_p   (rc_p),
        .primed (primed)
    );

    assign wrap       = primed && (rc_p == RC_WRAP_HI) && (rc_s == RC_WRAP_LO);
    assign upper_next = upper + UPPER_W'(wrap);
    // Modulo subtraction keeps intervals exact across a wrap of the wide count.
    assign elapsed    = count_r - base;
    assign start_ok   = (state == IDLE) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upper   <= '0;
            count_r <= '0;
            base    <= '0;
            tgt     <= '0;
            state   <= IDLE;
        end else begin
            upper   <= upper_next;
            count_r <= {upper_next, rc_s};
            if (start_ok) begin
                tgt <= bus.target;
            end
            if (state == ARM) begin
                base <= count_r;
            end
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = ARM;
            ARM:  state_nxt = RUN;
            RUN:  if (elapsed >= tgt) state_nxt = DONE;
            DONE: if (bus.ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.count = count_r;
    assign bus.busy  = (state == ARM) || (state == RUN);
    assign bus.done  = (state == DONE);

`ifdef RC_ERR_CHECK_EN
    logic            err_r;
    logic [RC_W-1:0] delta;

    assign delta = rc_delta(rc_s, rc_p);

    // An accepted start clears the flag; the caller is expected to have seen it by then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (start_ok) begin
            err_r <= 1'b0;
        end else if (primed && (delta > RC_W'(1))) begin
            err_r <= 1'b1;
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_rc_timer.sv
// Directed bench: ripple counter model feeding two rc_timer builds (UPPER_W=12 and UPPER_W=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_rc_timer;

    logic       clk;
    logic       rst;
    logic       r0, r1, r2, r3;
    logic       force_en;
    logic [3:0] force_val;
    logic [3:0] rc_q;
    int         cyc;
    int         n_checks;
    int         n_fail;
    int         exp_q[$];

    rc_timer_if #(.CNT_W(16)) bus_a ();
    rc_timer_if #(.CNT_W(6))  bus_b ();

    rc_timer #(.UPPER_W(12)) dut_a (.clk(clk), .rst(rst), .rc_q(rc_q), .bus(bus_a));
    rc_timer #(.UPPER_W(2))  dut_b (.clk(clk), .rst(rst), .rc_q(rc_q), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ripple counter: bit 0 toggles on falling clk, each higher bit on the falling edge of the one below.
    always @(negedge clk or posedge rst) if (rst) r0 <= 1'b0; else r0 <= ~r0;
    always @(negedge r0  or posedge rst) if (rst) r1 <= 1'b0; else r1 <= ~r1;
    always @(negedge r1  or posedge rst) if (rst) r2 <= 1'b0; else r2 <= ~r2;
    always @(negedge r2  or posedge rst) if (rst) r3 <= 1'b0; else r3 <= ~r3;

    assign rc_q = force_en ? force_val : {r3, r2, r1, r0};

    // Rising edges since reset release; with release just after a falling edge, count == cyc-2.
    always @(posedge clk or posedge rst) if (rst) cyc <= 0; else cyc <= cyc + 1;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input bit sel, input int t);
        if (sel) begin
            bus_b.target = 6'(t);
            bus_b.start  = 1'b1;
        end else begin
            bus_a.target = 16'(t);
            bus_a.start  = 1'b1;
        end
        // Start is taken on the next rising edge (cyc+1); done follows max(t+1, 2) edges later.
        exp_q.push_back(cyc + 1 + ((t == 0) ? 2 : t + 1));
        tick();
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int   exp_cyc;
        int   n;
        logic d;
        exp_cyc = exp_q.pop_front();
        n = 0;
        d = sel ? bus_b.done : bus_a.done;
        while (d !== 1'b1 && n < 300) begin
            tick();
            n++;
            d = sel ? bus_b.done : bus_a.done;
        end
        check({tag, "_done"}, 32'(d), 32'd1);
        check({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    endtask

    task automatic pulse_ack(input bit sel);
        if (sel) bus_b.ack = 1'b1; else bus_a.ack = 1'b1;
        tick();
        bus_a.ack = 1'b0;
        bus_b.ack = 1'b0;
    endtask

    initial begin
        int   n;
        logic exp_err;
`ifdef RC_ERR_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        force_en     = 1'b0;
        force_val    = 4'h0;
        bus_a.start  = 1'b0;
        bus_a.ack    = 1'b0;
        bus_a.target = '0;
        bus_b.start  = 1'b0;
        bus_b.ack    = 1'b0;
        bus_b.target = '0;

        // Reset state
        repeat (3) @(posedge clk);
        tick();
        check("rst_count", 32'(bus_a.count), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_done", 32'(bus_a.done), 32'd0);
        check("rst_err", 32'(bus_a.err), 32'd0);
        rst = 1'b0;

        // First wrap of the low nibble
        repeat (17) tick();
        check("pre_wrap_count", 32'(bus_a.count), 32'd15);
        tick();
        check("first_wrap_count", 32'(bus_a.count), 32'd16);
        check("first_wrap_count_b", 32'(bus_b.count), 32'd16);

        // Interval of 5, done held without ack
        do_start(1'b0, 5);
        check("t5_busy", 32'(bus_a.busy), 32'd1);
        check("t5_done_early", 32'(bus_a.done), 32'd0);
        wait_done(1'b0, "t5");
        check("t5_busy_in_done", 32'(bus_a.busy), 32'd0);
        repeat (10) tick();
        check("t5_done_held", 32'(bus_a.done), 32'd1);
        pulse_ack(1'b0);
        check("t5_ack_done", 32'(bus_a.done), 32'd0);
        check("t5_ack_busy", 32'(bus_a.busy), 32'd0);

        // Zero target
        do_start(1'b0, 0);
        wait_done(1'b0, "t0");
        pulse_ack(1'b0);

        // Spurious start and ack while running must not disturb target or state
        do_start(1'b0, 20);
        bus_a.start  = 1'b1;
        bus_a.target = 16'd1;
        bus_a.ack    = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_a.ack   = 1'b0;
        check("spur_busy", 32'(bus_a.busy), 32'd1);
        wait_done(1'b0, "t20");

        // start together with ack in DONE: ack wins, start dropped
        bus_a.start = 1'b1;
        bus_a.ack   = 1'b1;
        tick();
        bus_a.start = 1'b0;
        bus_a.ack   = 1'b0;
        check("sa_done", 32'(bus_a.done), 32'd0);
        check("sa_busy", 32'(bus_a.busy), 32'd0);
        tick();
        check("sa_busy_next", 32'(bus_a.busy), 32'd0);

        // Narrow build: wide count wraps 63 -> 0
        n = 0;
        while ((cyc % 64) != 1 && n < 100) begin tick(); n++; end
        check("b_count_63", 32'(bus_b.count), 32'd63);
        check("a_count_track", 32'(bus_a.count), 32'(16'(cyc - 2)));
        tick();
        check("b_count_wrap0", 32'(bus_b.count), 32'd0);

        // Interval spanning the narrow count wrap
        n = 0;
        while ((cyc % 64) != 56 && n < 100) begin tick(); n++; end
        do_start(1'b1, 20);
        wait_done(1'b1, "b_t20");
        check("b_t20_count", 32'(bus_b.count), 32'(6'(cyc - 2)));
        pulse_ack(1'b1);

        // Reset in the middle of a run
        do_start(1'b0, 100);
        repeat (30) tick();
        check("mid_busy", 32'(bus_a.busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(bus_a.count), 32'd0);
        check("mid_rst_busy", 32'(bus_a.busy), 32'd0);
        check("mid_rst_done", 32'(bus_a.done), 32'd0);
        check("mid_rst_count_b", 32'(bus_b.count), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check("post_rst_count", 32'(bus_a.count), 32'd3);

        // Illegal nibble step 3 -> 7
        n = 0;
        while (rc_q != 4'd4 && n < 40) begin tick(); n++; end
        force_val = 4'd7;
        force_en  = 1'b1;
        tick();
        force_en = 1'b0;
        tick();
        check("err_set", 32'(bus_a.err), 32'(exp_err));
        check("err_set_b", 32'(bus_b.err), 32'(exp_err));
        repeat (5) tick();
        check("err_sticky", 32'(bus_a.err), 32'(exp_err));
        do_start(1'b0, 0);
        check("err_clear", 32'(bus_a.err), 32'd0);
        check("err_other_kept", 32'(bus_b.err), 32'(exp_err));
        wait_done(1'b0, "err_t0");
        pulse_ack(1'b0);

        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
